// File: rtl/vram_arbiter.sv
// VRAM arbiter: gives the video fetch path absolute priority on a single-port
// RAM and lets two requesters share the remaining slots round-robin, but only
// inside the blanking update window that opens after each i_animate pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_DISPLAY | active display; requesters locked out, wait for i_animate
// ST_UPDATE  | update window open; grants allowed while i_blanking=1
// ST_GUARD   | per-frame op budget used up; wait for blanking to end
module vram_arbiter #(
   parameter int AW     = 12,
   parameter int DW     = 8,
   parameter int MAXOPS = 1024
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_blanking,
   input  logic          i_animate,
   input  logic          i_vid_req,
   input  logic [AW-1:0] i_vid_addr,
   output logic          o_vid_valid,
   output logic [DW-1:0] o_vid_data,
   input  logic [1:0]    i_req,
   input  logic [1:0]    i_we,
   input  logic [AW-1:0] i_addr0,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_wdata0,
   input  logic [DW-1:0] i_wdata1,
   output logic [1:0]    o_gnt,
   output logic [1:0]    o_rvalid,
   output logic [DW-1:0] o_rdata,
   output logic          o_ram_en,
   output logic          o_ram_we,
   output logic [AW-1:0] o_ram_addr,
   output logic [DW-1:0] o_ram_wdata,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_frame_tick,
   output logic [1:0]    o_state
);

   typedef enum logic [1:0] {
      ST_DISPLAY = 2'd0,
      ST_UPDATE  = 2'd1,
      ST_GUARD   = 2'd2
   } state_t;

   localparam logic [15:0] MAX_OPS = 16'(MAXOPS);

   state_t      state_q, state_d;
   logic [15:0] ops_q, ops_d;
   logic        prio_q, prio_d;        // requester favoured when both ask
   logic        tick_q, tick_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic        vid_valid_q, vid_valid_d;

   logic        vid_acc;
   logic        gnt_ok;
   logic        sel;
   logic [1:0]  gnt;

   // Arbitration and RAM port steering for the current cycle
   always_comb begin
      vid_acc     = i_rst & i_vid_req;
      gnt_ok      = i_rst & ~i_vid_req & (state_q == ST_UPDATE) & i_blanking
                    & (ops_q < MAX_OPS) & (|i_req);
      sel         = (i_req == 2'b11) ? prio_q : i_req[1];
      gnt         = 2'b00;
      o_ram_en    = 1'b0;
      o_ram_we    = 1'b0;
      o_ram_addr  = '0;
      o_ram_wdata = '0;
      if (vid_acc) begin
         o_ram_en   = 1'b1;
         o_ram_addr = i_vid_addr;
      end else if (gnt_ok) begin
         gnt[sel]    = 1'b1;
         o_ram_en    = 1'b1;
         o_ram_we    = sel ? i_we[1] : i_we[0];
         o_ram_addr  = sel ? i_addr1 : i_addr0;
         o_ram_wdata = sel ? i_wdata1 : i_wdata0;
      end
   end

   // Next-state, op counting, round-robin pointer and return tracking
   always_comb begin
      state_d     = state_q;
      ops_d       = ops_q;
      prio_d      = prio_q;
      tick_d      = 1'b0;
      rvalid_d    = gnt & ~i_we;
      vid_valid_d = vid_acc;
      if (gnt_ok) begin
         ops_d  = ops_q + 16'd1;
         prio_d = ~sel;
      end
      case (state_q)
         ST_DISPLAY: begin
            if (i_animate) begin
               state_d = ST_UPDATE;
               ops_d   = 16'd0;
               tick_d  = 1'b1;
            end
         end
         ST_UPDATE: begin
            if (!i_blanking)
               state_d = ST_DISPLAY;
            else if (gnt_ok && ops_d == MAX_OPS)
               state_d = ST_GUARD;
         end
         ST_GUARD: begin
            if (!i_blanking)
               state_d = ST_DISPLAY;
         end
         default: state_d = ST_DISPLAY;
      endcase
   end

   // State and return registers; reset is synchronous and active-low
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q     <= ST_DISPLAY;
         ops_q       <= 16'd0;
         prio_q      <= 1'b0;
         tick_q      <= 1'b0;
         rvalid_q    <= 2'b00;
         vid_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ops_q       <= ops_d;
         prio_q      <= prio_d;
         tick_q      <= tick_d;
         rvalid_q    <= rvalid_d;
         vid_valid_q <= vid_valid_d;
      end
   end

   // Returns in flight when reset asserts are dropped immediately
   assign o_gnt        = gnt;
   assign o_rvalid     = rvalid_q & {2{i_rst}};
   assign o_vid_valid  = vid_valid_q & i_rst;
   assign o_rdata      = i_ram_rdata;
   assign o_vid_data   = i_ram_rdata;
   assign o_frame_tick = tick_q;
   assign o_state      = state_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 12, RAM address width.
REQ-002 Parameter DW, default 8, RAM data width.
REQ-003 Parameter MAXOPS, default 1024, maximum requester transactions granted per frame (1..65535).
REQ-004 i_clk  in  1  pixel clock (40 MHz); all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-low.
REQ-006 i_blanking  in  1  from timing generator; high during blanking.
REQ-007 i_animate  in  1  one-cycle pulse at end of last active line.
REQ-008 i_vid_req / i_vid_addr  in  1 / AW  video pixel-fetch read request and address.
REQ-009 o_vid_valid / o_vid_data  out  1 / DW  video read return.
REQ-010 i_req[1:0], i_we[1:0]  in  2 each  requester request and write-enable; requester n uses bit n.
REQ-011 i_addr0, i_addr1  in  AW each; i_wdata0, i_wdata1  in  DW each.
REQ-012 o_gnt[1:0]  out  2  one-cycle acceptance pulse per requester.
REQ-013 o_rvalid[1:0] / o_rdata  out  2 / DW  requester read return.
REQ-014 o_ram_en, o_ram_we  out  1 each; o_ram_addr  out  AW; o_ram_wdata  out  DW; i_ram_rdata  in  DW; single-port RAM, 1-cycle read latency.
REQ-015 o_frame_tick  out  1  one-cycle pulse at the start of each update window.
REQ-016 o_state  out  2  current FSM state (DISPLAY=0, UPDATE=1, GUARD=2).

Function
REQ-017 FSM DISPLAY: no requester grants; on i_animate=1 -> UPDATE, o_frame_tick=1 in the following cycle, op counter cleared to 0.
REQ-018 UPDATE: requester grants permitted while i_blanking=1; i_blanking=0 -> DISPLAY; op counter reaching MAXOPS -> GUARD.
REQ-019 GUARD: no requester grants; i_blanking=0 -> DISPLAY; i_animate ignored.
REQ-020 i_animate in UPDATE or GUARD ignored (no restart, no o_frame_tick).
REQ-021 Video has absolute priority: i_vid_req=1 drives RAM (en=1, we=0, addr=i_vid_addr) in that cycle in any state, and no grant is issued that cycle.
REQ-022 o_vid_valid=1 exactly one cycle after each accepted video request, o_vid_data=i_ram_rdata in that cycle.
REQ-023 Grant condition, combinational in cycle: state=UPDATE, i_blanking=1, i_vid_req=0, counter<MAXOPS, at least one i_req bit set.
REQ-024 Arbitration round-robin: when both request, grant the one not granted most recently; pointer reset to favour requester 0; single requester always wins.
REQ-025 Granted cycle: RAM driven with that requester's addr, we, wdata; o_gnt bit high one cycle; requester holds req/addr/we/wdata stable until its grant.
REQ-026 Granted read (we=0): o_rvalid[n]=1 one cycle later with o_rdata=i_ram_rdata; writes produce no rvalid.
REQ-027 Op counter (16 bit) increments once per grant, saturates at MAXOPS; transition to GUARD occurs on the grant that makes counter=MAXOPS.
REQ-028 Simultaneous i_blanking fall and pending request in UPDATE: no grant that cycle (REQ-023), state -> DISPLAY.
REQ-029 A read granted in the last UPDATE cycle still returns o_rvalid next cycle regardless of state.
REQ-030 Idle cycles: o_ram_en=0, o_ram_we=0; o_ram_addr/o_ram_wdata don't-care.
REQ-031 At most one of {video access, o_gnt[0], o_gnt[1]} per cycle; o_ram_we=1 never coincides with i_vid_req=1.

Reset
REQ-032 i_rst=0 at a rising edge: state=DISPLAY, counter=0, RR pointer favours requester 0, all registered outputs 0 next cycle.
REQ-033 During reset, o_gnt=0, o_ram_en=0, o_ram_we=0 combinationally; in-flight rvalid/vid_valid discarded.
REQ-034 Reset mid-UPDATE aborts the window; first grant thereafter requires a new i_animate.

Verification
REQ-035 Reset, i_blanking=1, i_req=2'b11 with no i_animate -> o_gnt stays 0, o_state=0.
REQ-036 i_animate pulse, i_blanking=1, both requesting continuously -> o_frame_tick next cycle, grants alternate 01,10,01,... starting with requester 0.
REQ-037 UPDATE, requester 1 read addr 0x005 with RAM holding 0xA5 -> o_gnt=2'b10, next cycle o_rvalid=2'b10, o_rdata=0xA5.
REQ-038 UPDATE, i_vid_req=1 with i_req=2'b01 -> RAM addr=i_vid_addr, we=0, o_gnt=0; grant follows when i_vid_req drops.
REQ-039 MAXOPS=4, continuous requests -> exactly 4 grants, o_state=2, no further grants until next frame.
REQ-040 i_blanking falls while i_req=2'b01 in UPDATE -> no grant, o_state=0 next cycle; i_rst=0 mid-UPDATE -> o_state=0, counter=0.
